// File: rtl/dram_read_response_assembler.sv
// Collects multi-beat DRAM read responses into full scratchpad rows, one slot per
// outstanding dram_data_id, and hands completed rows to the write queue in completion order.
module dram_read_response_assembler #(
  parameter int ID_W      = 5,
  parameter int NUM_IDS   = 32,
  parameter int BEAT_W    = 128,
  parameter int MAX_BEATS = 4,
  parameter int ROW_W     = BEAT_W * MAX_BEATS,
  parameter int XBAR_W    = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              issue_valid,
  input  logic [ID_W-1:0]   issue_id,
  input  logic [1:0]        issue_nbeats_m1,
  input  logic              issue_row_or_col,
  input  logic [XBAR_W-1:0] issue_xbar,
  output logic              issue_ready,
  input  logic              dr_rvalid,
  input  logic [ID_W-1:0]   dr_rid,
  input  logic [BEAT_W-1:0] dr_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic              out_row_or_col,
  output logic [XBAR_W-1:0] out_xbar,
  output logic [ROW_W-1:0]  out_wdata,
  output logic [ID_W:0]     outstanding_cnt,
  output logic              err_unexpected_beat,
  output logic [ID_W-1:0]   err_id
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } entry_state_e;

  entry_state_e      r_state     [NUM_IDS];
  entry_state_e      w_stateNext [NUM_IDS];
  logic [1:0]        r_nbeatsM1  [NUM_IDS];
  logic [1:0]        r_beatCnt   [NUM_IDS];
  logic              r_rowOrCol  [NUM_IDS];
  logic [XBAR_W-1:0] r_xbar      [NUM_IDS];
  logic [ROW_W-1:0]  r_data      [NUM_IDS];
  logic [ID_W-1:0]   r_fifo      [NUM_IDS];
  logic [ID_W:0]     r_head;
  logic [ID_W:0]     r_tail;
  logic [ID_W:0]     r_outstanding;
  logic              r_err;
  logic [ID_W-1:0]   r_errId;

  logic              w_issueFire;
  logic              w_beatOk;
  logic              w_beatLast;
  logic              w_outValid;
  logic              w_outFire;
  logic [ID_W-1:0]   w_headId;

  // A beat is only accepted by an entry that is mid-collection; anything else is unexpected.
  assign issue_ready = (r_state[issue_id] == ST_FREE);
  assign w_issueFire = issue_valid && issue_ready;
  assign w_beatOk    = dr_rvalid && (r_state[dr_rid] == ST_COLLECT);
  assign w_beatLast  = w_beatOk && (r_beatCnt[dr_rid] == r_nbeatsM1[dr_rid]);
  assign w_outValid  = (r_head != r_tail);
  assign w_outFire   = w_outValid && out_ready;
  assign w_headId    = r_fifo[r_head[ID_W-1:0]];

  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) begin
      w_stateNext[i] = r_state[i];
      if (w_outFire && (w_headId == ID_W'(i))) begin
        w_stateNext[i] = ST_FREE;
      end
      if (w_issueFire && (issue_id == ID_W'(i))) begin
        w_stateNext[i] = ST_COLLECT;
      end
      if (w_beatLast && (dr_rid == ID_W'(i))) begin
        w_stateNext[i] = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        r_state[i] <= ST_FREE;
      end
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        r_state[i] <= w_stateNext[i];
      end
    end
  end

  // Payload storage needs no reset: an entry is only observed after an issue has initialised it.
  always_ff @(posedge clk) begin
    if (w_issueFire) begin
      r_nbeatsM1[issue_id] <= issue_nbeats_m1;
      r_beatCnt[issue_id]  <= 2'd0;
      r_rowOrCol[issue_id] <= issue_row_or_col;
      r_xbar[issue_id]     <= issue_xbar;
      r_data[issue_id]     <= '0;
    end
    if (w_beatOk) begin
      r_beatCnt[dr_rid] <= r_beatCnt[dr_rid] + 2'd1;
      for (int b = 0; b < MAX_BEATS; b++) begin
        if (r_beatCnt[dr_rid] == 2'(b)) begin
          r_data[dr_rid][b*BEAT_W +: BEAT_W] <= dr_rdata;
        end
      end
    end
    if (w_beatLast) begin
      r_fifo[r_tail[ID_W-1:0]] <= dr_rid;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_errId       <= '0;
    end else begin
      if (w_beatLast) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_outFire) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_issueFire, w_outFire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (dr_rvalid && !w_beatOk && !r_err) begin
        r_err   <= 1'b1;
        r_errId <= dr_rid;
      end
    end
  end

  // Output fields read as zero whenever nothing is queued, including right after reset.
  assign out_valid           = w_outValid;
  assign out_id              = w_outValid ? w_headId : '0;
  assign out_row_or_col      = w_outValid ? r_rowOrCol[w_headId] : 1'b0;
  assign out_xbar            = w_outValid ? r_xbar[w_headId] : '0;
  assign out_wdata           = w_outValid ? r_data[w_headId] : '0;
  assign outstanding_cnt     = r_outstanding;
  assign err_unexpected_beat = r_err;
  assign err_id              = r_errId;

endmodule
